lm32_tlb_assoc: RTL and testbench

//  Parametrised N-way set-associative TLB, next generation of the direct-mapped ITLB; one instance serves I- or D-side.

---
 rtl/lm32_tlb_assoc_pkg.sv | 26 ++
 rtl/lm32_tlb_assoc_if.sv | 35 +++
 rtl/lm32_tlb_assoc_match.sv | 42 ++++
 rtl/lm32_tlb_assoc.sv | 264 ++++++++++++++++++++++++++
 tb/tb_lm32_tlb_assoc.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lm32_tlb_assoc_pkg.sv
// Shared types for the set-associative TLB: command opcodes, controller states and
// a width helper used for way indices.
package lm32_tlb_assoc_pkg;

    typedef enum logic [1:0] {
        OpUpdate    = 2'd0,
        OpInvalVpn  = 2'd1,
        OpFlushAsid = 2'd2,
        OpFlushAll  = 2'd3
    } tlb_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StCmdRd,
        StCmdWr,
        StWalkRd,
        StWalkWr,
        StFlush
    } tlb_state_e;

    // Index width that never collapses to zero bits (a 1-way TLB still has a way index).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lm32_tlb_assoc_if.sv
// Lookup, miss and command signals between the pipeline/kernel (master) and the TLB (slave).
interface lm32_tlb_assoc_if #(
    parameter int unsigned ASID_WIDTH = 6
);
    logic                  tlb_enable;
    logic [ASID_WIDTH-1:0] cur_asid;
    logic                  lookup_en;
    logic [31:0]           lookup_vaddr;
    logic                  lookup_ready;
    logic                  hit;
    logic                  miss;
    logic [31:0]           paddr;
    logic [31:0]           miss_vaddr;
    logic                  miss_ack;
    logic                  cmd_valid;
    logic [1:0]            cmd_op;
    logic [31:0]           cmd_vaddr;
    logic [31:0]           cmd_paddr;
    logic [ASID_WIDTH-1:0] cmd_asid;
    logic                  cmd_global;
    logic                  cmd_ready;
    logic                  busy;

    modport master (
        output tlb_enable, cur_asid, lookup_en, lookup_vaddr, miss_ack,
               cmd_valid, cmd_op, cmd_vaddr, cmd_paddr, cmd_asid, cmd_global,
        input  lookup_ready, hit, miss, paddr, miss_vaddr, cmd_ready, busy
    );

    modport slave (
        input  tlb_enable, cur_asid, lookup_en, lookup_vaddr, miss_ack,
               cmd_valid, cmd_op, cmd_vaddr, cmd_paddr, cmd_asid, cmd_global,
        output lookup_ready, hit, miss, paddr, miss_vaddr, cmd_ready, busy
    );
endinterface

// File: rtl/lm32_tlb_assoc_match.sv
// Per-way tag/ASID compare for one set, lowest matching way index and its PPN.
// Purely combinational; entry layout is {valid, global, asid, tag, ppn}.
module lm32_tlb_match #(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned ASID_WIDTH = 6,
    parameter int unsigned TAGW       = 12,
    parameter int unsigned VPNW       = 20,
    parameter int unsigned WAYW       = 1
) (
    input  logic [WAYS-1:0][2+ASID_WIDTH+TAGW+VPNW-1:0] entries,
    input  logic [TAGW-1:0]                             tag,
    input  logic [ASID_WIDTH-1:0]                       asid,
    output logic [WAYS-1:0]                             match_vec,
    output logic                                        match_any,
    output logic [WAYW-1:0]                             match_way,
    output logic [VPNW-1:0]                             match_ppn
);
    localparam int unsigned EW      = 2 + ASID_WIDTH + TAGW + VPNW;
    localparam int unsigned TAG_LO  = VPNW;
    localparam int unsigned ASID_LO = VPNW + TAGW;
    localparam int unsigned GLB     = EW - 2;
    localparam int unsigned VLD     = EW - 1;

    always_comb begin
        match_vec = '0;
        match_way = '0;
        match_ppn = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            match_vec[w] = entries[w][VLD] && (entries[w][TAG_LO +: TAGW] == tag) &&
                           (entries[w][GLB] || (entries[w][ASID_LO +: ASID_WIDTH] == asid));
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (match_vec[w]) match_way = WAYW'(w);
        end
        for (int w = 0; w < int'(WAYS); w++) begin
            if (WAYW'(w) == match_way) match_ppn = entries[w][VPNW-1:0];
        end
    end

    assign match_any = |match_vec;

endmodule

// File: rtl/lm32_tlb_assoc.sv
// N-way set-associative TLB with ASID tags, global pages, round-robin victims and a
// command port for update, per-VPN invalidate, per-ASID flush and full flush.
module lm32_tlb_assoc
    import lm32_tlb_assoc_pkg::*;
#(
    parameter int unsigned SETS       = 256,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned PAGE_SIZE  = 4096,
    parameter int unsigned ASID_WIDTH = 6
) (
    input logic             clk_i,
    input logic             rst_i,
    lm32_tlb_assoc_if.slave bus
);
    localparam int unsigned IDXW    = $clog2(SETS);
    localparam int unsigned OFFW    = $clog2(PAGE_SIZE);
    localparam int unsigned VPNW    = 32 - OFFW;
    localparam int unsigned TAGW    = VPNW - IDXW;
    localparam int unsigned WAYW    = idx_width(WAYS);
    localparam int unsigned EW      = 2 + ASID_WIDTH + TAGW + VPNW;
    localparam int unsigned ASID_LO = VPNW + TAGW;
    localparam int unsigned GLB     = EW - 2;
    localparam int unsigned VLD     = EW - 1;

    tlb_state_e            state_q, state_d;
    logic [IDXW-1:0]       set_q, set_d;
    tlb_op_e               op_q;
    logic [TAGW-1:0]       ctag_q;
    logic [VPNW-1:0]       cppn_q;
    logic [ASID_WIDTH-1:0] casid_q;
    logic                  cglobal_q;

    logic                  lk_valid_q, lk_en_q;
    logic [31:0]           lk_vaddr_q;
    logic [ASID_WIDTH-1:0] lk_asid_q;
    logic                  miss_q;
    logic [31:0]           miss_vaddr_q;

    logic                  idle, cmd_accept, lk_accept, miss_now;
    logic [IDXW-1:0]       rd_idx;
    logic [WAYS-1:0][EW-1:0] rdata, wdata;
    logic [WAYS-1:0]       we;

    logic [WAYS-1:0]       lm_vec, cm_vec;
    logic                  lm_any, cm_any;
    logic [WAYW-1:0]       lm_way, cm_way;
    logic [VPNW-1:0]       lm_ppn, cm_ppn;
    logic [WAYW-1:0]       victim_way, inv_way, upd_way;
    logic                  any_inv, victim_use;
    logic                  unused_bits;

    assign idle       = (state_q == StIdle);
    assign cmd_accept = bus.cmd_valid & idle;
    assign lk_accept  = bus.lookup_en & idle & ~bus.cmd_valid;
    // Lookups own the read port in IDLE; commands and walks read the set in set_q.
    assign rd_idx     = idle ? bus.lookup_vaddr[OFFW+IDXW-1:OFFW] : set_q;

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_accept) begin
                    unique case (tlb_op_e'(bus.cmd_op))
                        OpUpdate, OpInvalVpn: begin
                            state_d = StCmdRd;
                            set_d   = bus.cmd_vaddr[OFFW+IDXW-1:OFFW];
                        end
                        OpFlushAsid: begin
                            state_d = StWalkRd;
                            set_d   = IDXW'(SETS - 1);
                        end
                        default: begin
                            state_d = StFlush;
                            set_d   = IDXW'(SETS - 1);
                        end
                    endcase
                end
            end
            StCmdRd:  state_d = StCmdWr;
            StCmdWr:  state_d = StIdle;
            StWalkRd: state_d = StWalkWr;
            StWalkWr: begin
                set_d   = set_q - 1'b1;
                state_d = (set_q == '0) ? StIdle : StWalkRd;
            end
            StFlush: begin
                set_d   = set_q - 1'b1;
                state_d = (set_q == '0) ? StIdle : StFlush;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StFlush;
            set_q     <= IDXW'(SETS - 1);
            op_q      <= OpFlushAll;
            ctag_q    <= '0;
            cppn_q    <= '0;
            casid_q   <= '0;
            cglobal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            if (cmd_accept) begin
                op_q      <= tlb_op_e'(bus.cmd_op);
                ctag_q    <= bus.cmd_vaddr[31:OFFW+IDXW];
                cppn_q    <= bus.cmd_paddr[31:OFFW];
                casid_q   <= bus.cmd_asid;
                cglobal_q <= bus.cmd_global;
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [EW-1:0] mem [SETS];
        logic [EW-1:0] rd_q;
        always_ff @(posedge clk_i) begin
            if (we[w]) mem[set_q] <= wdata[w];
            rd_q <= mem[rd_idx];
        end
        assign rdata[w] = rd_q;
    end

    lm32_tlb_match #(
        .WAYS(WAYS), .ASID_WIDTH(ASID_WIDTH), .TAGW(TAGW), .VPNW(VPNW), .WAYW(WAYW)
    ) u_match_lk (
        .entries   (rdata),
        .tag       (lk_vaddr_q[31:OFFW+IDXW]),
        .asid      (lk_asid_q),
        .match_vec (lm_vec),
        .match_any (lm_any),
        .match_way (lm_way),
        .match_ppn (lm_ppn)
    );

    lm32_tlb_match #(
        .WAYS(WAYS), .ASID_WIDTH(ASID_WIDTH), .TAGW(TAGW), .VPNW(VPNW), .WAYW(WAYW)
    ) u_match_cmd (
        .entries   (rdata),
        .tag       (ctag_q),
        .asid      (casid_q),
        .match_vec (cm_vec),
        .match_any (cm_any),
        .match_way (cm_way),
        .match_ppn (cm_ppn)
    );

    // Lowest-numbered invalid way is preferred over the victim pointer.
    always_comb begin
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!rdata[w][VLD]) begin
                any_inv = 1'b1;
                inv_way = WAYW'(w);
            end
        end
    end

    assign upd_way    = cm_any ? cm_way : (any_inv ? inv_way : victim_way);
    assign victim_use = (state_q == StCmdWr) && (op_q == OpUpdate) && !cm_any && !any_inv;

    always_comb begin
        we    = '0;
        wdata = '0;
        unique case (state_q)
            StFlush: we = '1;
            StWalkWr: begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (rdata[w][VLD] && !rdata[w][GLB] &&
                        (rdata[w][ASID_LO +: ASID_WIDTH] == casid_q)) begin
                        we[w]         = 1'b1;
                        wdata[w]      = rdata[w];
                        wdata[w][VLD] = 1'b0;
                    end
                end
            end
            StCmdWr: begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (op_q == OpInvalVpn && cm_vec[w]) begin
                        we[w]         = 1'b1;
                        wdata[w]      = rdata[w];
                        wdata[w][VLD] = 1'b0;
                    end else if (op_q == OpUpdate && WAYW'(w) == upd_way) begin
                        we[w]    = 1'b1;
                        wdata[w] = {1'b1, cglobal_q, casid_q, ctag_q, cppn_q};
                    end
                end
            end
            default: ;
        endcase
    end

    if (WAYS > 1) begin : g_victim
        logic [WAYW-1:0] victim_q [SETS];
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int unsigned s = 0; s < SETS; s++) victim_q[IDXW'(s)] <= '0;
            end else if (state_q == StFlush) begin
                victim_q[set_q] <= '0;
            end else if (victim_use) begin
                victim_q[set_q] <= victim_q[set_q] + 1'b1;
            end
        end
        assign victim_way = victim_q[set_q];
    end else begin : g_no_victim
        logic unused_victim;
        assign unused_victim = victim_use;
        assign victim_way    = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lk_valid_q <= 1'b0;
            lk_en_q    <= 1'b0;
            lk_vaddr_q <= '0;
            lk_asid_q  <= '0;
        end else begin
            lk_valid_q <= lk_accept;
            if (lk_accept) begin
                lk_en_q    <= bus.tlb_enable;
                lk_vaddr_q <= bus.lookup_vaddr;
                lk_asid_q  <= bus.cur_asid;
            end
        end
    end

    assign miss_now = lk_valid_q & lk_en_q & ~lm_any;

    // Ack beats a coincident miss; only the first unacked miss address is kept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            miss_q       <= 1'b0;
            miss_vaddr_q <= '0;
        end else if (bus.miss_ack) begin
            miss_q <= 1'b0;
        end else if (miss_now) begin
            miss_q <= 1'b1;
            if (!miss_q) miss_vaddr_q <= lk_vaddr_q;
        end
    end

    always_comb begin
        bus.paddr = '0;
        if (lk_valid_q) begin
            if (!lk_en_q)    bus.paddr = lk_vaddr_q;
            else if (lm_any) bus.paddr = {lm_ppn, lk_vaddr_q[OFFW-1:0]};
        end
    end

    assign bus.hit          = lk_valid_q & (~lk_en_q | lm_any);
    assign bus.miss         = miss_q;
    assign bus.miss_vaddr   = miss_vaddr_q;
    assign bus.lookup_ready = idle;
    assign bus.cmd_ready    = idle;
    assign bus.busy         = ~idle;

    assign unused_bits = ^{bus.cmd_vaddr[OFFW-1:0], bus.cmd_paddr[OFFW-1:0], lm_vec, lm_way,
                           cm_ppn};

endmodule

// File: tb/tb_lm32_tlb_assoc.sv
// Directed bench for lm32_tlb_assoc: vector table per phase plus hand sequences for
// command timing, miss stickiness and reset during a walk.
module tb_lm32_tlb_assoc;
    import lm32_tlb_assoc_pkg::*;

    localparam int unsigned SETS  = 16;
    localparam int unsigned WAYS  = 2;
    localparam int unsigned ASIDW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lm32_tlb_assoc_if #(.ASID_WIDTH(ASIDW)) bus ();

    lm32_tlb_assoc #(
        .SETS(SETS), .WAYS(WAYS), .PAGE_SIZE(4096), .ASID_WIDTH(ASIDW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int          phase;
        logic [31:0] va;
        logic [5:0]  asid;
        logic        en;
        logic        hit;
        logic [31:0] pa;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input int p, input logic [31:0] va, input logic [5:0] asid,
                       input logic en, input logic hit, input logic [31:0] pa);
        vec_t v;
        v.phase = p; v.va = va; v.asid = asid; v.en = en; v.hit = hit; v.pa = pa;
        vecs.push_back(v);
    endtask

    task automatic count_to_ready(input int start, output int cnt);
        cnt = start;
        while (!bus.cmd_ready && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic do_cmd(input tlb_op_e op, input logic [31:0] va, input logic [31:0] pa,
                          input logic [5:0] asid, input logic glob, input int exp_cnt,
                          input string name);
        int cnt;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_vaddr  = va;
        bus.cmd_paddr  = pa;
        bus.cmd_asid   = asid;
        bus.cmd_global = glob;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        count_to_ready(1, cnt);
        check(name, cnt, exp_cnt);
    endtask

    task automatic lookup(input logic [31:0] va, input logic [5:0] asid, input logic en);
        bus.lookup_en    = 1'b1;
        bus.lookup_vaddr = va;
        bus.cur_asid     = asid;
        bus.tlb_enable   = en;
        @(negedge clk);
        bus.lookup_en = 1'b0;
    endtask

    task automatic ack_miss();
        bus.miss_ack = 1'b1;
        @(negedge clk);
        bus.miss_ack = 1'b0;
    endtask

    task automatic run_phase(input int p);
        logic exp_miss;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].phase == p) begin
                exp_miss = vecs[i].en & ~vecs[i].hit;
                lookup(vecs[i].va, vecs[i].asid, vecs[i].en);
                check($sformatf("p%0d_v%0d_hit", p, i), bus.hit, vecs[i].hit);
                check($sformatf("p%0d_v%0d_paddr", p, i), bus.paddr, vecs[i].pa);
                @(negedge clk);
                check($sformatf("p%0d_v%0d_hit_once", p, i), bus.hit, 0);
                check($sformatf("p%0d_v%0d_miss", p, i), bus.miss, exp_miss);
                if (exp_miss)
                    check($sformatf("p%0d_v%0d_miss_vaddr", p, i), bus.miss_vaddr,
                          vecs[i].va);
                if (bus.miss) ack_miss();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        bus.tlb_enable = 1'b1; bus.cur_asid = '0; bus.lookup_en = 1'b0;
        bus.lookup_vaddr = '0; bus.miss_ack = 1'b0; bus.cmd_valid = 1'b0;
        bus.cmd_op = '0; bus.cmd_vaddr = '0; bus.cmd_paddr = '0;
        bus.cmd_asid = '0; bus.cmd_global = 1'b0;

        add(0, 32'h1234_5678, 0, 1, 0, 32'h0);
        add(0, 32'h0040_1ABC, 5, 0, 1, 32'h0040_1ABC);
        add(1, 32'h0040_1ABC, 5, 1, 1, 32'h8000_3ABC);
        add(1, 32'h0040_1ABC, 6, 1, 0, 32'h0);
        add(1, 32'h0040_1000, 6, 0, 1, 32'h0040_1000);
        add(1, 32'h0040_2000, 5, 1, 0, 32'h0);
        add(1, 32'h0041_1000, 5, 1, 0, 32'h0);
        add(1, 32'h0040_1FFF, 5, 1, 1, 32'h8000_3FFF);
        add(2, 32'h0010_3004, 1, 1, 0, 32'h0);
        add(2, 32'h0020_3008, 1, 1, 1, 32'h0B00_0008);
        add(2, 32'h0030_300C, 1, 1, 1, 32'h0C00_000C);
        add(2, 32'h0040_1ABC, 5, 1, 1, 32'h8000_3ABC);
        add(3, 32'h0020_3010, 1, 1, 1, 32'h0D00_0010);
        add(4, 32'h0020_3010, 1, 1, 0, 32'h0);
        add(4, 32'h0030_3010, 1, 1, 1, 32'h0C00_0010);
        add(4, 32'h0060_3010, 1, 1, 1, 32'h0E00_0010);
        add(5, 32'h0050_5123, 7, 1, 1, 32'h9000_5123);
        add(5, 32'h0060_6123, 3, 1, 1, 32'h9100_6123);
        add(5, 32'h0060_6123, 7, 1, 0, 32'h0);
        add(6, 32'h0050_5123, 3, 1, 1, 32'h9000_5123);
        add(6, 32'h0060_6123, 3, 1, 0, 32'h0);
        add(6, 32'h0070_7456, 4, 1, 1, 32'h9200_7456);
        add(6, 32'h0040_1ABC, 5, 1, 1, 32'h8000_3ABC);
        add(7, 32'h0040_1ABC, 5, 1, 0, 32'h0);
        add(7, 32'h0030_3010, 1, 1, 1, 32'h0C00_0010);
        add(8, 32'h0050_5123, 3, 1, 0, 32'h0);
        add(8, 32'h0030_3010, 1, 1, 0, 32'h0);
        add(8, 32'h0070_7456, 4, 1, 0, 32'h0);

        // Reset values, then the power-on flush takes SETS cycles.
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_lookup_ready", bus.lookup_ready, 0);
        check("rst_hit", bus.hit, 0);
        check("rst_miss", bus.miss, 0);
        check("rst_paddr", bus.paddr, 0);
        check("rst_miss_vaddr", bus.miss_vaddr, 0);
        rst = 1'b0;
        count_to_ready(0, cnt);
        check("rst_flush_cycles", cnt, SETS);
        check("idle_lookup_ready", bus.lookup_ready, 1);
        run_phase(0);

        do_cmd(OpUpdate, 32'h0040_1000, 32'h8000_3000, 5, 0, 3, "upd_a_cycles");
        run_phase(1);

        do_cmd(OpUpdate, 32'h0010_3000, 32'h0A00_0000, 1, 0, 3, "fill0_cycles");
        do_cmd(OpUpdate, 32'h0020_3000, 32'h0B00_0000, 1, 0, 3, "fill1_cycles");
        do_cmd(OpUpdate, 32'h0030_3000, 32'h0C00_0000, 1, 0, 3, "fill2_cycles");
        run_phase(2);
        do_cmd(OpUpdate, 32'h0020_3000, 32'h0D00_0000, 1, 0, 3, "reupd_cycles");
        run_phase(3);
        do_cmd(OpUpdate, 32'h0060_3000, 32'h0E00_0000, 1, 0, 3, "fill3_cycles");
        run_phase(4);

        do_cmd(OpUpdate, 32'h0050_5000, 32'h9000_5000, 3, 1, 3, "upd_glob_cycles");
        do_cmd(OpUpdate, 32'h0060_6000, 32'h9100_6000, 3, 0, 3, "upd_priv_cycles");
        do_cmd(OpUpdate, 32'h0070_7000, 32'h9200_7000, 4, 0, 3, "upd_asid4_cycles");
        run_phase(5);

        // Command and lookup in the same cycle: command wins, lookup dropped.
        bus.cmd_valid = 1'b1; bus.cmd_op = OpInvalVpn; bus.cmd_vaddr = 32'h00AA_A000;
        bus.cmd_asid = 0; bus.cmd_global = 1'b0;
        bus.lookup_en = 1'b1; bus.lookup_vaddr = 32'h0050_5123; bus.cur_asid = 3;
        bus.tlb_enable = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.lookup_en = 1'b0;
        check("cmd_beats_lookup_hit", bus.hit, 0);
        check("cmd_beats_lookup_busy", bus.busy, 1);
        count_to_ready(1, cnt);
        check("inval_nomatch_cycles", cnt, 3);
        check("cmd_beats_lookup_miss", bus.miss, 0);

        do_cmd(OpFlushAsid, 32'h0, 32'h0, 3, 0, 2 * SETS + 1, "flush_asid_cycles");
        run_phase(6);
        do_cmd(OpInvalVpn, 32'h0040_1000, 32'h0, 5, 0, 3, "inval_cycles");
        run_phase(7);

        // Sticky miss keeps the first address; commands leave it alone.
        lookup(32'h0000_1000, 0, 1);
        lookup(32'h0000_2000, 0, 1);
        @(negedge clk);
        check("sticky_miss", bus.miss, 1);
        check("sticky_miss_vaddr", bus.miss_vaddr, 32'h0000_1000);
        do_cmd(OpInvalVpn, 32'h00BB_B000, 32'h0, 0, 0, 3, "inval_during_miss_cycles");
        check("miss_kept_over_cmd", bus.miss, 1);
        ack_miss();
        check("miss_acked", bus.miss, 0);
        lookup(32'h0000_3000, 0, 1);
        bus.miss_ack = 1'b1;
        @(negedge clk);
        bus.miss_ack = 1'b0;
        check("ack_beats_miss", bus.miss, 0);
        lookup(32'h0000_4000, 0, 1);
        @(negedge clk);
        check("miss_after_ack", bus.miss, 1);
        check("miss_after_ack_vaddr", bus.miss_vaddr, 32'h0000_4000);
        ack_miss();

        // Reset in the middle of a FLUSH_ASID walk restarts the full flush.
        bus.cmd_valid = 1'b1; bus.cmd_op = OpFlushAsid; bus.cmd_asid = 9;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("walk_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cmd_ready", bus.cmd_ready, 0);
        rst = 1'b0;
        count_to_ready(0, cnt);
        check("mid_rst_flush_cycles", cnt, SETS);
        run_phase(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
